// File: rtl/score_display.sv
// Score display: converts the binary score to BCD with a sequential double-dabble engine,
// tracks the session high score and multiplexes score, high score, mole and level onto 8 digits.
module score_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [5:0] score,
  input  logic [2:0] mole_pos1,
  input  logic [1:0] levl,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] score_bcd,
  output logic [7:0] hi_bcd,
  output logic       busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [5:0]       score_q, last_bin, hi_bin, operand;
  logic [13:0]      sr;
  logic [2:0]       shift_cnt;
  logic [CNT_W-1:0] refresh_cnt;
  logic [2:0]       digit_idx;
  logic [3:0]       digit;
  logic             blank;

  // One double-dabble step: correct any BCD nibble >= 5, then shift the whole word left.
  function automatic logic [13:0] dabble_step(input logic [13:0] v);
    logic [13:0] t;
    t = v;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'b1000000;
      4'd1: seg_code = 7'b1111001;
      4'd2: seg_code = 7'b0100100;
      4'd3: seg_code = 7'b0110000;
      4'd4: seg_code = 7'b0011001;
      4'd5: seg_code = 7'b0010010;
      4'd6: seg_code = 7'b0000010;
      4'd7: seg_code = 7'b1111000;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0010000;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (score_q != last_bin) state_n = SHIFT;
      SHIFT:   if (shift_cnt == 3'd5)   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      score_q   <= '0;
      last_bin  <= '0;
      hi_bin    <= '0;
      score_bcd <= '0;
      hi_bcd    <= '0;
    end else begin
      state   <= state_n;
      busy    <= (state_n != IDLE);
      score_q <= score;
      if (state == DONE) begin
        score_bcd <= sr[13:6];
        last_bin  <= operand;
        if (operand > hi_bin) begin
          hi_bin <= operand;
          hi_bcd <= sr[13:6];
        end
      end
    end
  end

  // NOTE: the engine datapath carries no reset; IDLE always loads it before it is read.
  always_ff @(posedge CLK100MHZ) begin
    if (state == IDLE && state_n == SHIFT) begin
      sr        <= {8'b0, score_q};
      operand   <= score_q;
      shift_cnt <= '0;
    end else if (state == SHIFT) begin
      sr        <= dabble_step(sr);
      shift_cnt <= shift_cnt + 3'd1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Tens digits are blanked rather than shown as a leading zero.
  always_comb begin
    digit = 4'd0;
    blank = 1'b1;
    case (digit_idx)
      3'd0: begin digit = score_bcd[3:0]; blank = 1'b0; end
      3'd1: begin digit = score_bcd[7:4]; blank = (score_bcd[7:4] == 4'd0); end
      3'd4: begin digit = hi_bcd[3:0];    blank = 1'b0; end
      3'd5: begin digit = hi_bcd[7:4];    blank = (hi_bcd[7:4] == 4'd0); end
      3'd6: begin digit = {1'b0, mole_pos1}; blank = 1'b0; end
      3'd7: begin digit = {2'b00, levl} + 4'd1; blank = 1'b0; end
      default: begin digit = 4'd0; blank = 1'b1; end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else if (blank) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else begin
      an  <= ~(8'd1 << digit_idx);
      seg <= seg_code(digit);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display; expectations come from decimal arithmetic
// on the score and a slot schedule derived from the number of clock edges since reset release.
module tb_score_display;

  logic       clk;
  logic       rst_n;
  logic [5:0] score;
  logic [2:0] mole_pos1;
  logic [1:0] levl;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] score_bcd;
  logic [7:0] hi_bcd;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int edges;
  int m_score, m_hi, m_mole, m_levl;

  logic [6:0] seg_tab [10];

  score_display #(.REFRESH_DIV(4)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .score     (score),
    .mole_pos1 (mole_pos1),
    .levl      (levl),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .score_bcd (score_bcd),
    .hi_bcd    (hi_bcd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since reset release; the display schedule is a pure function of this.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // {an, seg} expected after the given number of edges with the model's displayed values.
  function automatic logic [14:0] exp_disp(input int e);
    int slot, d;
    if (e == 0) return {8'hFF, 7'h7F};
    slot = ((e - 1) / 4) % 8;
    case (slot)
      0: d = m_score % 10;
      1: d = (m_score / 10 == 0) ? -1 : m_score / 10;
      4: d = m_hi % 10;
      5: d = (m_hi / 10 == 0) ? -1 : m_hi / 10;
      6: d = m_mole;
      7: d = m_levl + 1;
      default: d = -1;
    endcase
    if (d < 0) return {8'hFF, 7'h7F};
    return {~(8'd1 << slot), seg_tab[d]};
  endfunction

  task automatic check_display(input string tag);
    logic [14:0] x;
    x = exp_disp(edges);
    check({tag, ".an"}, 32'(an), 32'(x[14:7]));
    check({tag, ".seg"}, 32'(seg), 32'(x[6:0]));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_display(tag);
    end
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_score(input int v);
    score   = 6'(v);
    m_score = v;
    if (v > m_hi) m_hi = v;
  endtask

  initial begin
    int t_hit, t10, t63, first_new;
    logic busy_seen;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    rst_n = 1'b0; score = '0; mole_pos1 = '0; levl = '0;
    m_score = 0; m_hi = 0; m_mole = 0; m_levl = 0;

    repeat (3) @(negedge clk);
    check("rst.an", 32'(an), 32'hFF);
    check("rst.seg", 32'(seg), 32'h7F);
    check("rst.dp", 32'(dp), 32'h1);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.score_bcd", 32'(score_bcd), 32'h0);
    check("rst.hi_bcd", 32'(hi_bcd), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle.busy", 32'(busy), 32'h0);
    end
    sweep("zero");

    // 0 -> 37 with exact latency measurement
    @(negedge clk);
    set_score(37);
    t_hit = 0; busy_seen = 1'b0;
    for (int k = 1; k <= 20 && t_hit == 0; k++) begin
      @(posedge clk); #1;
      if (busy) busy_seen = 1'b1;
      if (score_bcd == 8'h37) t_hit = k;
    end
    check("s37.latency", 32'(t_hit), 32'd9);
    check("s37.busy_seen", 32'(busy_seen), 32'h1);
    check("s37.hi_bcd", 32'(hi_bcd), 32'h37);
    settle();
    sweep("s37");

    set_score(5);
    settle();
    check("s5.score_bcd", 32'(score_bcd), 32'h05);
    check("s5.hi_bcd", 32'(hi_bcd), 32'h37);
    sweep("s5");

    // 10, then 63 while the first conversion is shifting
    set_score(10);
    t10 = 0; t63 = 0; first_new = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 3) set_score(63);
      if (first_new < 0 && score_bcd != 8'h05) begin first_new = int'(score_bcd); t10 = k; end
      if (t63 == 0 && score_bcd == 8'h63) t63 = k;
    end
    check("s10.first", 32'(first_new), 32'h10);
    check("s10.latency", 32'(t10), 32'd9);
    check("s63.gap", 32'(t63 - t10), 32'd8);
    check("s63.score_bcd", 32'(score_bcd), 32'h63);
    check("s63.hi_bcd", 32'(hi_bcd), 32'h63);

    @(negedge clk);
    mole_pos1 = 3'd6; levl = 2'd3; m_mole = 6; m_levl = 3;
    @(negedge clk);
    sweep("mole");

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_score(int'($urandom_range(0, 63)));
      m_mole = int'($urandom_range(0, 7));
      m_levl = int'($urandom_range(0, 3));
      mole_pos1 = 3'(m_mole); levl = 2'(m_levl);
      settle();
      check("rnd.busy", 32'(busy), 32'h0);
      check("rnd.score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
      check("rnd.hi_bcd", 32'(hi_bcd), 32'(to_bcd(m_hi)));
      check_display("rnd");
    end

    // Reset during the third shift cycle of a conversion of 45
    @(negedge clk);
    set_score(45);
    if (m_score == 45 && score_bcd == 8'h45) begin
      set_score(44); settle(); set_score(45);
    end
    repeat (4) @(posedge clk);
    #2;
    check("rst45.busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    m_hi = 0; m_score = 0;
    #1;
    check("rst45.busy", 32'(busy), 32'h0);
    check("rst45.score_bcd", 32'(score_bcd), 32'h0);
    check("rst45.hi_bcd", 32'(hi_bcd), 32'h0);
    check("rst45.an", 32'(an), 32'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_score(45);
    settle();
    check("rst45.reconv", 32'(score_bcd), 32'h45);
    check("rst45.hi_reconv", 32'(hi_bcd), 32'h45);
    sweep("rst45");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
